// File: rtl/cam_access_arbiter.sv
// cam_access_arbiter
//
// Shares one 16x8 content-addressable memory between two requesters.
// Round-robin arbitration picks the winner, and only one CAM operation is in
// flight at a time. The winner's request is latched and driven onto the CAM
// pins for exactly one cycle. For a lookup, the block waits CAM_LAT cycles and
// then captures the match result. Every operation ends with a one-cycle tagged
// response on the rsp_* bus.
//
// Optional feature macro: CAM_WR_PRIO_EN
//   When defined and both requesters are valid with exactly one write, the
//   writer wins regardless of the round-robin pointer. Without the macro,
//   arbitration is pure round-robin.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN_valid/ready        N=0,1 request handshake (ready only in IDLE)
//   reqN_op                 0 = lookup, 1 = write
//   reqN_key                search key / write data
//   reqN_addr               write address (ignored for lookup)
//   cam_wen/ren/din/addr    drive the CAM, non-zero only during ISSUE
//   cam_dout, cam_hit       CAM lookup result
//   rsp_valid/id/hit/addr   one-cycle response strobe with owner and result

module cam_access_arbiter #(
    parameter int DW      = 8,
    parameter int AW      = 4,
    parameter int CAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_op,
    input  logic [DW-1:0] req0_key,
    input  logic [AW-1:0] req0_addr,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_op,
    input  logic [DW-1:0] req1_key,
    input  logic [AW-1:0] req1_addr,
    output logic          cam_wen,
    output logic          cam_ren,
    output logic [DW-1:0] cam_din,
    output logic [AW-1:0] cam_addr,
    input  logic [AW-1:0] cam_dout,
    input  logic          cam_hit,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic          rsp_hit,
    output logic [AW-1:0] rsp_addr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CW = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    logic [1:0]    state;
    logic          last_grant;
    logic          op_q;
    logic          id_q;
    logic [DW-1:0] key_q;
    logic [AW-1:0] addr_q;
    logic          hit_q;
    logic [AW-1:0] res_addr_q;
    logic [CW-1:0] wait_cnt;

    logic          winner;
    logic          any_valid;
    logic          grant_ok;

    // Winner selection. A lone requester always wins. When both requesters
    // are valid, the one that was not granted last wins, unless write
    // priority is enabled and the two ops differ.
    always_comb begin
        winner    = 1'b0;
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef CAM_WR_PRIO_EN
            if (req0_op != req1_op) begin
                winner = req1_op;
            end else begin
                winner = ~last_grant;
            end
`else
            winner = ~last_grant;
`endif
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Ready is gated by rst_n so that every output reads 0 while reset is held.
    assign grant_ok   = rst_n && (state == IDLE) && any_valid;
    assign req0_ready = grant_ok & ~winner;
    assign req1_ready = grant_ok & winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            id_q       <= 1'b0;
            key_q      <= '0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            res_addr_q <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // In IDLE, any valid requester means the winner completes its handshake.
                    if (any_valid) begin
                        op_q       <= winner ? req1_op   : req0_op;
                        key_q      <= winner ? req1_key  : req0_key;
                        addr_q     <= winner ? req1_addr : req0_addr;
                        id_q       <= winner;
                        last_grant <= winner;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_q) begin
                        hit_q      <= 1'b0;
                        res_addr_q <= addr_q;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= CW'(CAM_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The CAM result is valid in the last WAIT cycle. A miss reports address 0.
                    if (wait_cnt == '0) begin
                        hit_q      <= cam_hit;
                        res_addr_q <= cam_hit ? cam_dout : '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // CAM pins are decoded from state, so reset forces them low immediately.
    assign cam_wen  = (state == ISSUE) & op_q;
    assign cam_ren  = (state == ISSUE) & ~op_q;
    assign cam_din  = (state == ISSUE) ? key_q : '0;
    assign cam_addr = ((state == ISSUE) && op_q) ? addr_q : '0;

    assign rsp_valid = (state == RESP);
    assign rsp_id    = (state == RESP) & id_q;
    assign rsp_hit   = (state == RESP) & hit_q;
    assign rsp_addr  = (state == RESP) ? res_addr_q : '0;

endmodule
